jtsbaskt_objdraw: RTL and testbench
===================================

JTSBASKT_OBJDRAW -- requirements
Module: jtsbaskt_objdraw

Interface
REQ-001 The parameter HOFFSET SHALL default to 8'd6 and set the horizontal offset added to hdump[7:0] when the line buffer is read.
REQ-002 The parameter BYPASS_PROM SHALL default to 0; when it is 1, the raw ROM nibble SHALL replace the PROM lookup result.
REQ-003 Reset and clock: rst is asynchronous and active-high; clk is the clock (48 MHz).
REQ-004 Signal list (name  direction  width  meaning):
  rst  in  1  asynchronous active-high reset
  clk  in  1  48 MHz clock
  pxl_cen  in  1  pixel clock enable
  cen2  in  1  half-rate enable (every other clk)
  LHBL  in  1  horizontal blank, active low
  hinit_x  in  1  line start, stretched to cover one cen2
  hdump  in  9  horizontal dump counter
  draw  in  1  one-cen2 request; latch the sprite fields
  busy  out  1  drawer occupied
  code  in  9  sprite code
  xpos  in  8  left x coordinate
  pal  in  4  palette
  hflip, vflip  in  1 each  flip flags
  ysub  in  4  row within the sprite
  prog_data  in  4  PROM write data
  prog_addr  in  8  PROM write address
  prog_en  in  1  PROM write enable
  rom_cs  out  1  ROM request
  rom_addr  out  14  ROM word address
  rom_data  in  32  ROM data, 8 packed 4-bit pixels
  rom_ok  in  1  ROM data valid
  pxl  out  4  colour index, 0 = transparent

Function
REQ-005 The block SHALL advance its FSM only on cycles where cen2=1; pxl output logic SHALL advance only on cycles where pxl_cen=1.
REQ-006 The FSM SHALL have the states IDLE, FETCH and DRAW.
REQ-007 In IDLE, when draw=1, the block SHALL latch code, xpos, pal, hflip, vflip and ysub, clear half to 0, and go to FETCH.
REQ-008 busy SHALL be registered and SHALL be 1 in every state except IDLE.
REQ-009 Row address: yrow = vflip ? ~ysub : ysub.
REQ-010 Word address: rom_addr = {code, yrow, half ^ hflip}.
REQ-011 rom_cs SHALL be 1 throughout FETCH and 0 in every other state.
REQ-012 In FETCH, when rom_ok=1, the block SHALL capture rom_data into a 32-bit shifter, set pixcnt to 0, and go to DRAW.
REQ-013 In DRAW, the block SHALL emit one pixel per cen2, taking nibble n = pixcnt for hflip=0 and n = 7-pixcnt for hflip=1, where nibble n = rom_data[4n+3:4n].
REQ-014 Colour lookup: colour = PROM[{pal, nibble}].
REQ-015 The PROM SHALL be 256x4, written when prog_en=1 at prog_addr with prog_data, with synchronous read; the write path SHALL be pipelined so that the lookup latency is invisible to the pixel count.
REQ-016 Line-buffer write address = xpos + half*8 + pixcnt, using 8-bit arithmetic that wraps modulo 256; pixels past x=255 SHALL land at low x.
REQ-017 Transparency: a pixel whose colour is 0 SHALL NOT be written; the existing buffer content SHALL be kept.
REQ-018 Overlap: a later sprite SHALL overwrite the pixels of an earlier sprite.
REQ-019 After pixcnt=7: if half=0, the block SHALL set half=1 and go to FETCH; if half=1, it SHALL go to IDLE, and busy SHALL fall one cen2 later.
REQ-020 The line buffer SHALL consist of two 256x4 banks; the write bank is ~lsel and the read bank is lsel.
REQ-021 lsel SHALL toggle on each cen2 cycle where hinit_x=1, at most once per hinit_x pulse.
REQ-022 When hinit_x=1 while the FSM is in FETCH or DRAW, the FSM SHALL abort to IDLE, drop rom_cs, and drop busy on the next cen2.
REQ-023 If draw and hinit_x are both 1 on the same cen2, hinit_x SHALL win and draw SHALL be ignored.
REQ-024 Read side: on pxl_cen while LHBL=1, the block SHALL read the read bank at hdump[7:0] + HOFFSET (wrapping modulo 256), register the value into pxl, and write 0 to that location (read-and-clear).
REQ-025 pxl SHALL be 0 when LHBL=0, and the buffer SHALL NOT be cleared during blanking.
REQ-026 A read-and-clear and a write SHALL never collide, because they address different banks.

Reset
REQ-027 On rst: FSM = IDLE, busy = 0, rom_cs = 0, half = 0, pixcnt = 0, lsel = 0, pxl = 0.
REQ-028 PROM contents and line-buffer contents are undefined after reset and SHALL NOT be cleared by reset.
REQ-029 Assertion of rst during FETCH or DRAW SHALL take effect immediately, and no further buffer write SHALL occur.

Verification
REQ-030 The bench SHALL cover the following directed scenarios:
  1. Basic draw: PROM = identity, code=9'h005, ysub=3, no flips, xpos=8'h10, ROM word = 32'h87654321 with rom_ok after 4 cycles -> rom_addr 14'h00A6 then 14'h00A7; after the line swap, pxl reads 1,2,...,8 at x=0x10..0x17; busy is high for 2 fetches + 16 pixels.
  2. Flips: hflip=1, vflip=1, ysub=3 -> first rom_addr = {code,4'hC,1'b1}; pixels at xpos..xpos+7 are nibble 7 down to nibble 0.
  3. Wrap and transparency: xpos=8'hFC, a word with nibble 2 = 0 -> pixels land at 0xFC..0x03, the location for nibble 2 keeps its prior value, and no write occurs at 0x100.
  4. Abort: hinit_x asserted mid-DRAW at pixcnt=3 -> busy=0 and rom_cs=0 within 1 cen2, lsel toggles, no further writes; simultaneous draw is ignored.
  5. Read-and-clear: read the line once -> a second read of the same bank after two swaps returns 0 everywhere; pxl=0 while LHBL=0.
  6. Reset mid-FETCH with rom_ok held low -> rom_cs=0, busy=0, pxl=0, FSM in IDLE.

Source files
------------

// File: rtl/jtsbaskt_objdraw.sv
// ---------------------------------------------------------------------------
// jtsbaskt_objdraw
//
// Sprite line drawer. It fetches two 32-bit ROM words (eight 4-bit pixels
// each) for one 16-pixel-wide sprite row, maps every pixel through a 256x4
// palette PROM and writes the result into a double-buffered 256x4 line
// buffer. The opposite bank is read out at the pixel rate and cleared as it
// is read, so the next line starts empty.
//
// Ports
//   rst, clk       asynchronous active-high reset, 48 MHz clock
//   pxl_cen        pixel clock enable (read side and pxl register)
//   cen2           half-rate enable (drawer FSM)
//   LHBL           horizontal blank, active low
//   hinit_x        line start; swaps the banks and aborts any draw
//   hdump          horizontal counter, bits [7:0] address the read bank
//   draw, busy     sprite request / drawer occupied
//   code .. ysub   sprite fields, latched on an accepted draw
//   prog_*         PROM download port
//   rom_cs, rom_addr, rom_data, rom_ok   sprite ROM request/response
//   pxl            colour index out, 0 = transparent
// ---------------------------------------------------------------------------
module jtsbaskt_objdraw #(
  parameter logic [7:0] HOFFSET     = 8'd6,
  parameter bit         BYPASS_PROM = 1'b0
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        pxl_cen,
  input  logic        cen2,
  input  logic        LHBL,
  input  logic        hinit_x,
  input  logic [8:0]  hdump,
  input  logic        draw,
  output logic        busy,
  input  logic [8:0]  code,
  input  logic [7:0]  xpos,
  input  logic [3:0]  pal,
  input  logic        hflip,
  input  logic        vflip,
  input  logic [3:0]  ysub,
  input  logic [3:0]  prog_data,
  input  logic [7:0]  prog_addr,
  input  logic        prog_en,
  output logic        rom_cs,
  output logic [13:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        rom_ok,
  output logic [3:0]  pxl
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAW  = 2'd2
  } state_t;

  state_t      r_st;

  // latched sprite fields
  logic [8:0]  r_code;
  logic [7:0]  r_xpos;
  logic [3:0]  r_pal;
  logic        r_hflip;
  logic        r_vflip;
  logic [3:0]  r_ysub;

  logic        r_half;
  logic [2:0]  r_pixcnt;
  logic [31:0] r_data;
  logic        r_busy;
  logic        r_rom_cs;

  // pixel write pipeline: stage 1 is the PROM read, stage 2 the buffer write
  logic        r_pix_we;
  logic        r_wr_bank;
  logic [7:0]  r_wr_addr;
  logic [3:0]  r_nib_q;
  logic [3:0]  r_prom_q;

  logic        r_lsel;
  logic        r_hinit_l;
  logic [3:0]  r_pxl;

  logic [3:0]  r_prom [0:255];
  logic [3:0]  r_buf0 [0:255];
  logic [3:0]  r_buf1 [0:255];

  logic [3:0]  w_yrow;
  logic [2:0]  w_nib_idx;
  logic [3:0]  w_nib;
  logic [7:0]  w_pix_x;
  logic [3:0]  w_colour;
  logic [7:0]  w_rd_addr;
  logic [3:0]  w_rd_val;
  logic        w_rd_clr;
  logic        w_emit;
  logic        w_unused_hdump;

  assign w_yrow    = r_vflip ? ~r_ysub : r_ysub;
  assign rom_addr  = {r_code, w_yrow, r_half ^ r_hflip};
  assign rom_cs    = r_rom_cs;
  assign busy      = r_busy;
  assign pxl       = r_pxl;

  // with hflip the word is walked from its top nibble down
  assign w_nib_idx = r_hflip ? (3'd7 - r_pixcnt) : r_pixcnt;
  assign w_nib     = r_data[{w_nib_idx, 2'b00} +: 4];
  // 8-bit sum: pixels beyond x=255 wrap to the left edge
  assign w_pix_x   = r_xpos + {4'd0, r_half, 3'd0} + {5'd0, r_pixcnt};
  assign w_colour  = BYPASS_PROM ? r_nib_q : r_prom_q;

  assign w_rd_addr = hdump[7:0] + HOFFSET;
  assign w_rd_val  = r_lsel ? r_buf1[w_rd_addr] : r_buf0[w_rd_addr];
  assign w_rd_clr  = pxl_cen & LHBL;
  // hinit_x has priority, so no pixel is produced on a line-swap cycle
  assign w_emit    = cen2 & ~hinit_x & (r_st == ST_DRAW);
  assign w_unused_hdump = hdump[8];

  // drawer FSM: fetch two words, emit eight pixels per word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st      <= ST_IDLE;
      r_code    <= 9'd0;
      r_xpos    <= 8'd0;
      r_pal     <= 4'd0;
      r_hflip   <= 1'b0;
      r_vflip   <= 1'b0;
      r_ysub    <= 4'd0;
      r_half    <= 1'b0;
      r_pixcnt  <= 3'd0;
      r_data    <= 32'd0;
      r_busy    <= 1'b0;
      r_rom_cs  <= 1'b0;
      r_pix_we  <= 1'b0;
      r_wr_bank <= 1'b0;
      r_wr_addr <= 8'd0;
      r_nib_q   <= 4'd0;
    end else begin
      // write strobe lasts one clk; cen2 never fires on consecutive pixels
      r_pix_we <= 1'b0;
      if (cen2) begin
        case (r_st)
          ST_IDLE: begin
            if (!hinit_x && draw) begin
              r_code   <= code;
              r_xpos   <= xpos;
              r_pal    <= pal;
              r_hflip  <= hflip;
              r_vflip  <= vflip;
              r_ysub   <= ysub;
              r_half   <= 1'b0;
              r_st     <= ST_FETCH;
              r_busy   <= 1'b1;
              r_rom_cs <= 1'b1;
            end
          end
          ST_FETCH: begin
            if (hinit_x) begin
              r_st     <= ST_IDLE;
              r_busy   <= 1'b0;
              r_rom_cs <= 1'b0;
            end else if (rom_ok) begin
              r_data   <= rom_data;
              r_pixcnt <= 3'd0;
              r_st     <= ST_DRAW;
              r_rom_cs <= 1'b0;
            end
          end
          ST_DRAW: begin
            if (hinit_x) begin
              r_st   <= ST_IDLE;
              r_busy <= 1'b0;
            end else begin
              r_pix_we  <= 1'b1;
              r_wr_addr <= w_pix_x;
              r_wr_bank <= ~r_lsel;
              r_nib_q   <= w_nib;
              r_pixcnt  <= r_pixcnt + 3'd1;
              if (r_pixcnt == 3'd7) begin
                if (!r_half) begin
                  r_half   <= 1'b1;
                  r_st     <= ST_FETCH;
                  r_rom_cs <= 1'b1;
                end else begin
                  r_st   <= ST_IDLE;
                  r_busy <= 1'b0;
                end
              end
            end
          end
          default: begin
            r_st     <= ST_IDLE;
            r_busy   <= 1'b0;
            r_rom_cs <= 1'b0;
          end
        endcase
      end
    end
  end

  // palette PROM: download port plus synchronous lookup of the emitted nibble
  always_ff @(posedge clk) begin
    if (prog_en) begin
      r_prom[prog_addr] <= prog_data;
    end
    if (w_emit) begin
      r_prom_q <= r_prom[{r_pal, w_nib}];
    end
  end

  // bank 0: sprite write when it is the write bank, read-clear otherwise
  always_ff @(posedge clk) begin
    if (r_pix_we && !r_wr_bank && (w_colour != 4'd0)) begin
      r_buf0[r_wr_addr] <= w_colour;
    end else if (w_rd_clr && !r_lsel) begin
      r_buf0[w_rd_addr] <= 4'd0;
    end
  end

  // bank 1: same arrangement with the bank roles swapped
  always_ff @(posedge clk) begin
    if (r_pix_we && r_wr_bank && (w_colour != 4'd0)) begin
      r_buf1[r_wr_addr] <= w_colour;
    end else if (w_rd_clr && r_lsel) begin
      r_buf1[w_rd_addr] <= 4'd0;
    end
  end

  // bank select toggles once on the first cen2 of each hinit_x pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lsel    <= 1'b0;
      r_hinit_l <= 1'b0;
    end else if (cen2) begin
      r_hinit_l <= hinit_x;
      if (hinit_x && !r_hinit_l) begin
        r_lsel <= ~r_lsel;
      end
    end
  end

  // pixel output register, forced to 0 during blanking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pxl <= 4'd0;
    end else if (pxl_cen) begin
      r_pxl <= LHBL ? w_rd_val : 4'd0;
    end
  end

endmodule

// File: tb/tb_jtsbaskt_objdraw.sv
module tb_jtsbaskt_objdraw;

  logic        rst, clk, pxl_cen, cen2, LHBL, hinit_x, draw, busy;
  logic [8:0]  hdump, code;
  logic [7:0]  xpos, prog_addr;
  logic [3:0]  pal, ysub, prog_data, pxl;
  logic        hflip, vflip, prog_en, rom_cs, rom_ok;
  logic [13:0] rom_addr;
  logic [31:0] rom_data;

  jtsbaskt_objdraw dut (
    .rst(rst), .clk(clk), .pxl_cen(pxl_cen), .cen2(cen2), .LHBL(LHBL),
    .hinit_x(hinit_x), .hdump(hdump), .draw(draw), .busy(busy),
    .code(code), .xpos(xpos), .pal(pal), .hflip(hflip), .vflip(vflip),
    .ysub(ysub), .prog_data(prog_data), .prog_addr(prog_addr),
    .prog_en(prog_en), .rom_cs(rom_cs), .rom_addr(rom_addr),
    .rom_data(rom_data), .rom_ok(rom_ok), .pxl(pxl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rom_cnt = 0;
  bit rom_hold = 1'b0;
  bit last_cen2_edge = 1'b0;

  // reference model state
  logic [3:0] m_prom [256];
  logic [3:0] m_buf [2][256];
  bit         m_lsel = 1'b0;
  logic [3:0] rd_val [256];

  typedef struct {
    logic [8:0]  code;
    logic [7:0]  xpos;
    logic [3:0]  pal;
    logic        hf;
    logic        vf;
    logic [3:0]  ysub;
    logic [13:0] exp_addr;
  } vec_t;
  vec_t tbl [4];

  // watchdog
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not end, required to finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rom_word(input logic [13:0] a);
    case (a)
      14'h00A6, 14'h00A7, 14'h00B8, 14'h00B9: return 32'h87654321;
      14'h0400, 14'h0401:                     return 32'h87654021;
      default: return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A1234;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // one clk; enables and the ROM responder are updated after the edge
  task automatic tick();
    bit was;
    was = cen2;
    @(posedge clk);
    #1;
    last_cen2_edge = was;
    cen2 = ~cen2;
    pxl_cen = cen2;
    if (rom_cs === 1'b1 && !rst) rom_cnt++;
    else rom_cnt = 0;
    rom_ok = (rom_cnt >= 4) && !rom_hold;
    rom_data = rom_word(rom_addr);
  endtask

  task automatic wait_cen2();
    do tick(); while (!last_cen2_edge);
  endtask

  task automatic prog(input logic [7:0] a, input logic [3:0] d);
    prog_addr = a; prog_data = d; prog_en = 1'b1;
    tick();
    prog_en = 1'b0;
    m_prom[a] = d;
  endtask

  task automatic prog_identity();
    for (int i = 0; i < 256; i++) prog(8'(i), 4'(i));
  endtask

  task automatic swap();
    if (!cen2) tick();
    hinit_x = 1'b1;
    tick();
    tick();
    hinit_x = 1'b0;
    m_lsel = ~m_lsel;
  endtask

  // read the whole line once; the model is read-and-cleared alongside
  task automatic read_line(input bit cmp);
    logic [7:0] a;
    for (int h = 0; h < 256; h++) begin
      if (!cen2) tick();
      hdump = 9'(h); LHBL = 1'b1;
      tick();
      a = 8'(h) + 8'd6;
      rd_val[a] = pxl;
      if (cmp) check($sformatf("pxl x=%02h", a), pxl, m_buf[m_lsel][a]);
      m_buf[m_lsel][a] = 4'd0;
    end
    LHBL = 1'b0;
  endtask

  // sprite drawn straight from the rules: 16 pixels, two words, PROM map
  task automatic model_draw(input logic [8:0] c, input logic [7:0] x, input logic [3:0] p,
                            input logic hf, input logic vf, input logic [3:0] ys, input int npix);
    logic [3:0] yrow, nib, col;
    logic [31:0] w;
    logic [7:0] xa;
    int n;
    yrow = vf ? ~ys : ys;
    for (int i = 0; i < npix; i++) begin
      w = rom_word({c, yrow, 1'(i / 8) ^ hf});
      n = hf ? 7 - (i % 8) : (i % 8);
      nib = w[4*n +: 4];
      col = m_prom[{p, nib}];
      xa = x + 8'(i);
      if (col != 4'd0) m_buf[~m_lsel][xa] = col;
    end
  endtask

  task automatic start_draw(input logic [8:0] c, input logic [7:0] x, input logic [3:0] p,
                            input logic hf, input logic vf, input logic [3:0] ys);
    if (!cen2) tick();
    code = c; xpos = x; pal = p; hflip = hf; vflip = vf; ysub = ys;
    draw = 1'b1;
    tick();
    draw = 1'b0;
  endtask

  task automatic draw_sprite(input logic [8:0] c, input logic [7:0] x, input logic [3:0] p,
                             input logic hf, input logic vf, input logic [3:0] ys,
                             input logic [13:0] exp_a, input string tag);
    logic [13:0] addrs[$];
    logic [13:0] a1;
    int busy_clk, cs_clk, guard;
    logic prev_cs;
    busy_clk = 0; cs_clk = 0; guard = 0; prev_cs = 1'b0;
    start_draw(c, x, p, hf, vf, ys);
    check({tag, " busy_rise"}, busy, 1'b1);
    while (busy === 1'b1 && guard < 2000) begin
      if (rom_cs && !prev_cs) addrs.push_back(rom_addr);
      prev_cs = rom_cs;
      busy_clk++;
      if (rom_cs) cs_clk++;
      tick();
      guard++;
    end
    check({tag, " done_in_time"}, guard < 2000, 1'b1);
    check({tag, " fetches"}, addrs.size(), 2);
    a1 = {exp_a[13:1], ~exp_a[0]};
    if (addrs.size() >= 1) check({tag, " rom_addr0"}, addrs[0], exp_a);
    if (addrs.size() >= 2) check({tag, " rom_addr1"}, addrs[1], a1);
    check({tag, " busy_len"}, busy_clk, cs_clk + 32);
    model_draw(c, x, p, hf, vf, ys, 16);
  endtask

  initial begin
    int guard;
    logic [8:0] rc; logic [7:0] rx; logic [3:0] rp, ry; logic rh, rv;

    tbl[0] = '{9'h005, 8'h10, 4'h0, 1'b0, 1'b0, 4'h3, 14'h00A6};
    tbl[1] = '{9'h005, 8'h40, 4'h0, 1'b1, 1'b1, 4'h3, 14'h00B9};
    tbl[2] = '{9'h1FF, 8'h80, 4'h7, 1'b0, 1'b0, 4'h0, 14'h3FE0};
    tbl[3] = '{9'h100, 8'hF0, 4'hA, 1'b1, 1'b1, 4'h9, 14'h200D};

    rst = 1'b1; cen2 = 1'b0; pxl_cen = 1'b0; LHBL = 1'b0; hinit_x = 1'b0;
    hdump = 9'd0; draw = 1'b0; code = 9'd0; xpos = 8'd0; pal = 4'd0;
    hflip = 1'b0; vflip = 1'b0; ysub = 4'd0; prog_data = 4'd0;
    prog_addr = 8'd0; prog_en = 1'b0; rom_ok = 1'b0; rom_data = 32'd0;
    tick(); tick();
    check("reset busy", busy, 1'b0);
    check("reset rom_cs", rom_cs, 1'b0);
    check("reset pxl", pxl, 4'd0);
    rst = 1'b0;
    tick();

    prog_identity();
    // bring both banks to a known empty state
    read_line(1'b0); swap(); read_line(1'b0); swap();

    // table: basic, flips, extreme code, wrap with flips
    for (int i = 0; i < 4; i++) begin
      draw_sprite(tbl[i].code, tbl[i].xpos, tbl[i].pal, tbl[i].hf, tbl[i].vf,
                  tbl[i].ysub, tbl[i].exp_addr, $sformatf("vec%0d", i));
      swap();
      read_line(1'b1);
      if (i == 0) begin
        check("basic x10", rd_val[8'h10], 4'd1);
        check("basic x17", rd_val[8'h17], 4'd8);
      end
      if (i == 1) begin
        check("flip x40", rd_val[8'h40], 4'd8);
        check("flip x47", rd_val[8'h47], 4'd1);
      end
    end

    // wrap and transparency over an earlier sprite
    draw_sprite(9'h005, 8'hF8, 4'h0, 1'b0, 1'b0, 4'h3, 14'h00A6, "under");
    draw_sprite(9'h020, 8'hFC, 4'h0, 1'b0, 1'b0, 4'h0, 14'h0400, "wrap");
    swap();
    read_line(1'b1);
    check("wrap keep xFE", rd_val[8'hFE], 4'd7);
    check("wrap xFF", rd_val[8'hFF], 4'd4);
    check("wrap x00", rd_val[8'h00], 4'd5);
    check("wrap keep x06", rd_val[8'h06], 4'd7);
    check("wrap x0C", rd_val[8'h0C], 4'd0);

    // random PROM and sprites against the model
    for (int i = 0; i < 256; i++)
      prog(8'(i), ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15)));
    for (int ln = 0; ln < 3; ln++) begin
      for (int s = 0; s < 4; s++) begin
        rc = 9'($urandom); rx = 8'($urandom); rp = 4'($urandom);
        rh = 1'($urandom); rv = 1'($urandom); ry = 4'($urandom);
        draw_sprite(rc, rx, rp, rh, rv, ry, {rc, rv ? ~ry : ry, rh}, $sformatf("rnd%0d_%0d", ln, s));
      end
      swap();
      read_line(1'b1);
    end

    // abort mid-DRAW at pixcnt=3 with a simultaneous draw
    prog_identity();
    start_draw(9'h005, 8'h30, 4'h0, 1'b0, 1'b0, 4'h3);
    guard = 0;
    while (rom_cs === 1'b1 && guard < 100) begin tick(); guard++; end
    check("abort fetch_done", rom_cs, 1'b0);
    wait_cen2(); wait_cen2(); wait_cen2();
    hinit_x = 1'b1; draw = 1'b1; xpos = 8'h90;
    wait_cen2();
    check("abort busy", busy, 1'b0);
    check("abort rom_cs", rom_cs, 1'b0);
    draw = 1'b0;
    tick();
    hinit_x = 1'b0;
    model_draw(9'h005, 8'h30, 4'h0, 1'b0, 1'b0, 4'h3, 3);
    m_lsel = ~m_lsel;
    for (int i = 0; i < 4; i++) wait_cen2();
    check("abort draw_ignored", busy, 1'b0);
    read_line(1'b1);
    check("abort x32", rd_val[8'h32], 4'd3);
    check("abort x33", rd_val[8'h33], 4'd0);

    // a long hinit_x pulse swaps once only
    if (!cen2) tick();
    hinit_x = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    hinit_x = 1'b0;
    m_lsel = ~m_lsel;
    swap();
    // back on the bank read above: everything was cleared
    read_line(1'b1);
    check("clear x30", rd_val[8'h30], 4'd0);

    // blanking reads give 0 and leave the buffer intact
    draw_sprite(9'h005, 8'h10, 4'h0, 1'b0, 1'b0, 4'h3, 14'h00A6, "blank");
    swap();
    for (int h = 8; h < 21; h++) begin
      if (!cen2) tick();
      hdump = 9'(h); LHBL = 1'b0;
      tick();
      check($sformatf("blank pxl h=%0d", h), pxl, 4'd0);
    end
    read_line(1'b1);
    check("blank kept x10", rd_val[8'h10], 4'd1);

    // reset mid-FETCH with rom_ok held low
    rom_hold = 1'b1;
    start_draw(9'h005, 8'h60, 4'h0, 1'b0, 1'b0, 4'h3);
    for (int i = 0; i < 6; i++) tick();
    check("rstf rom_cs_before", rom_cs, 1'b1);
    rst = 1'b1;
    #1;
    check("rstf rom_cs", rom_cs, 1'b0);
    check("rstf busy", busy, 1'b0);
    check("rstf pxl", pxl, 4'd0);
    tick(); tick();
    rst = 1'b0;
    rom_hold = 1'b0;
    m_lsel = 1'b0;
    for (int i = 0; i < 4; i++) wait_cen2();
    check("rstf idle", busy, 1'b0);

    // reset mid-DRAW after two pixels: nothing more is written
    start_draw(9'h005, 8'h50, 4'h0, 1'b0, 1'b0, 4'h3);
    guard = 0;
    while (rom_cs === 1'b1 && guard < 100) begin tick(); guard++; end
    check("rstd fetch_done", rom_cs, 1'b0);
    wait_cen2(); wait_cen2();
    tick();
    rst = 1'b1;
    #1;
    check("rstd busy", busy, 1'b0);
    tick();
    rst = 1'b0;
    model_draw(9'h005, 8'h50, 4'h0, 1'b0, 1'b0, 4'h3, 2);
    for (int i = 0; i < 8; i++) tick();
    swap();
    read_line(1'b1);
    check("rstd x51", rd_val[8'h51], 4'd2);
    check("rstd x52", rd_val[8'h52], 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
